// File: rtl/writeback_ctrl.sv
// Writeback sequencer: turns ALU, load and register-move requests into register-file
// write strobes, holding upstream off while a load waits for data memory.
module writeback_ctrl #(
  parameter int DataSize       = 32,
  parameter int AddrSize       = 5,
  parameter int TimeoutCycles  = 15,
  parameter int ZeroRegProtect = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wb_valid,
  input  logic [1:0]          wb_type,
  input  logic [AddrSize-1:0] wb_dest,
  input  logic                dm_ready,
  input  logic                flush,
  output logic [1:0]          writeback_select,
  output logic                reg_write,
  output logic [AddrSize-1:0] write_addr,
  output logic                stall,
  output logic                load_timeout
);

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_MOVE = 2'b10;

  // An out-of-range parameter set degrades to a one-cycle load timeout.
  localparam bit ParamsOk = (DataSize > 0) && (TimeoutCycles >= 1) && (TimeoutCycles <= 255);
  localparam logic [7:0] TmoLast = ParamsOk ? 8'(TimeoutCycles - 1) : 8'd0;

  typedef enum logic {
    IDLE    = 1'b0,
    WAIT_DM = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [AddrSize-1:0]   dest_q, dest_d;
  logic                  we_q, we_d;
  logic [1:0]            sel_q, sel_d;
  logic [AddrSize-1:0]   addr_q, addr_d;
  logic                  tmo_q, tmo_d;

  function automatic logic write_allowed(input logic [AddrSize-1:0] dest);
    return !((ZeroRegProtect != 0) && (dest == '0));
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dest_q  <= '0;
      we_q    <= 1'b0;
      sel_q   <= WB_ALU;
      addr_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dest_q  <= dest_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dest_d  = dest_q;
    we_d    = 1'b0;
    sel_d   = WB_ALU;
    addr_d  = addr_q;
    tmo_d   = 1'b0;

    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (wb_valid) begin
            unique case (wb_type)
              WB_ALU, WB_MOVE: begin
                // Suppressed writes to r0 still present their select and address.
                we_d   = write_allowed(wb_dest);
                sel_d  = wb_type;
                addr_d = wb_dest;
              end
              WB_LOAD: begin
                dest_d  = wb_dest;
                cnt_d   = '0;
                state_d = WAIT_DM;
              end
              default: ;
            endcase
          end
        end
        WAIT_DM: begin
          if (dm_ready) begin
            we_d    = write_allowed(dest_q);
            sel_d   = WB_LOAD;
            addr_d  = dest_q;
            cnt_d   = '0;
            state_d = IDLE;
          end else if (cnt_q == TmoLast) begin
            tmo_d   = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign stall            = (state_q == WAIT_DM);
  assign reg_write        = we_q;
  assign writeback_select = sel_q;
  assign write_addr       = addr_q;
  assign load_timeout     = tmo_q;

endmodule

// File: tb/tb_writeback_ctrl.sv
// Bench for writeback_ctrl: directed vector table, multi-cycle corner sequences and
// randomized traffic against a transaction-level reference model.
module tb_writeback_ctrl;
  localparam int AW  = 5;
  localparam int TMO = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wb_valid = 1'b0;
  logic [1:0]    wb_type = 2'b00;
  logic [AW-1:0] wb_dest = '0;
  logic          dm_ready = 1'b0;
  logic          flush = 1'b0;
  logic [1:0]    writeback_select;
  logic          reg_write;
  logic [AW-1:0] write_addr;
  logic          stall;
  logic          load_timeout;

  always #5 clk = ~clk;

  writeback_ctrl #(
    .DataSize(32), .AddrSize(AW), .TimeoutCycles(TMO), .ZeroRegProtect(1)
  ) dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_type(wb_type), .wb_dest(wb_dest),
    .dm_ready(dm_ready), .flush(flush), .writeback_select(writeback_select),
    .reg_write(reg_write), .write_addr(write_addr), .stall(stall),
    .load_timeout(load_timeout)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic          v;
    logic [1:0]    t;
    logic [AW-1:0] d;
    logic          r;
    logic          f;
    logic          we;
    logic [1:0]    sel;
    logic [AW-1:0] addr;
    logic          st;
    logic          to;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(int v, int t, int d, int r, int f,
                              int we, int sel, int addr, int st, int to);
    vec_t x;
    x.v = v[0]; x.t = t[1:0]; x.d = d[AW-1:0]; x.r = r[0]; x.f = f[0];
    x.we = we[0]; x.sel = sel[1:0]; x.addr = addr[AW-1:0]; x.st = st[0]; x.to = to[0];
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic we, input logic [1:0] sel,
                           input logic [AW-1:0] addr, input logic st, input logic to);
    chk({tag, ".reg_write"}, 32'(reg_write), 32'(we));
    chk({tag, ".select"}, 32'(writeback_select), 32'(sel));
    chk({tag, ".write_addr"}, 32'(write_addr), 32'(addr));
    chk({tag, ".stall"}, 32'(stall), 32'(st));
    chk({tag, ".load_timeout"}, 32'(load_timeout), 32'(to));
  endtask

  task automatic drive(input logic v, input logic [1:0] t, input logic [AW-1:0] d,
                       input logic r, input logic f);
    wb_valid = v; wb_type = t; wb_dest = d; dm_ready = r; flush = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a pending-load record plus the last presented write.
  bit            m_busy;
  int            m_waited;
  logic [AW-1:0] m_ld_dest;
  logic          m_we;
  logic [1:0]    m_sel;
  logic [AW-1:0] m_addr;
  logic          m_to;

  task automatic model_reset();
    m_busy = 0; m_waited = 0; m_ld_dest = '0;
    m_we = 0; m_sel = 2'b00; m_addr = '0; m_to = 0;
  endtask

  task automatic model_write(input logic [1:0] src, input logic [AW-1:0] dest);
    m_we = (dest != 0);
    m_sel = src;
    m_addr = dest;
  endtask

  task automatic model_cycle(input logic v, input logic [1:0] t, input logic [AW-1:0] d,
                             input logic r, input logic f);
    m_we = 0; m_sel = 2'b00; m_to = 0;
    if (f) begin
      m_busy = 0;
    end else if (m_busy) begin
      m_waited++;
      if (r) begin
        model_write(2'b01, m_ld_dest);
        m_busy = 0;
      end else if (m_waited >= TMO) begin
        m_to = 1;
        m_busy = 0;
      end
    end else if (v) begin
      if (t == 2'b00 || t == 2'b10) model_write(t, d);
      else if (t == 2'b01) begin
        m_busy = 1; m_ld_dest = d; m_waited = 0;
      end
    end
  endtask

  initial begin
    tbl[0]  = mk(1, 0, 3, 0, 0,  1, 0, 3, 0, 0);
    tbl[1]  = mk(1, 1, 7, 0, 0,  0, 0, 3, 1, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0,  0, 0, 3, 1, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0,  0, 0, 3, 1, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0,  0, 0, 3, 1, 0);
    tbl[5]  = mk(1, 0, 5, 0, 0,  0, 0, 3, 1, 0);
    tbl[6]  = mk(0, 0, 0, 1, 0,  1, 1, 7, 0, 0);
    tbl[7]  = mk(1, 2, 9, 0, 0,  1, 2, 9, 0, 0);
    tbl[8]  = mk(1, 3, 4, 0, 0,  0, 0, 9, 0, 0);
    tbl[9]  = mk(0, 0, 0, 1, 0,  0, 0, 9, 0, 0);
    tbl[10] = mk(1, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    tbl[11] = mk(1, 2, 0, 0, 0,  0, 2, 0, 0, 0);
    tbl[12] = mk(1, 0, 6, 0, 1,  0, 0, 0, 0, 0);
    tbl[13] = mk(1, 1, 8, 0, 0,  0, 0, 0, 1, 0);
    tbl[14] = mk(0, 0, 0, 1, 1,  0, 0, 0, 0, 0);
    tbl[15] = mk(0, 0, 0, 1, 0,  0, 0, 0, 0, 0);
    tbl[16] = mk(1, 1, 0, 0, 0,  0, 0, 0, 1, 0);
    tbl[17] = mk(0, 0, 0, 1, 0,  0, 1, 0, 0, 0);
    tbl[18] = mk(1, 2, 31, 0, 0, 1, 2, 31, 0, 0);

    // Reset state
    drive(0, 0, 0, 0, 0);
    #12;
    check_out("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].t, tbl[i].d, tbl[i].r, tbl[i].f);
      tick();
      check_out($sformatf("vec%0d", i), tbl[i].we, tbl[i].sel, tbl[i].addr, tbl[i].st, tbl[i].to);
    end

    // Load abandoned after TMO waiting cycles
    drive(1, 1, 12, 0, 0);
    tick();
    check_out("tmo.accept", 0, 0, 31, 1, 0);
    drive(0, 0, 0, 0, 0);
    for (int k = 1; k < TMO; k++) begin
      tick();
      check_out($sformatf("tmo.wait%0d", k), 0, 0, 31, 1, 0);
    end
    tick();
    check_out("tmo.pulse", 0, 0, 31, 0, 1);
    tick();
    check_out("tmo.after", 0, 0, 31, 0, 0);

    // dm_ready on the last allowed cycle beats the timeout
    drive(1, 1, 13, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    for (int k = 1; k < TMO; k++) tick();
    check_out("race.wait", 0, 0, 31, 1, 0);
    drive(0, 0, 0, 1, 0);
    tick();
    check_out("race.write", 1, 1, 13, 0, 0);

    // Reset mid-load, then immediate acceptance after release
    drive(1, 1, 14, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    tick();
    #2;
    rst = 1'b0;
    #1;
    check_out("rstload.async", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    drive(1, 0, 2, 0, 0);
    tick();
    check_out("rstload.first", 1, 0, 2, 0, 0);
    drive(0, 0, 0, 1, 0);
    tick();
    check_out("rstload.noload", 0, 0, 2, 0, 0);
    drive(1, 0, 0, 0, 0);
    tick();
    check_out("rstload.r0", 0, 0, 0, 0, 0);

    // Randomized traffic against the reference model
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      logic          v, r, f;
      logic [1:0]    t;
      logic [AW-1:0] d;
      int            ready_div;
      ready_div = ((c / 200) % 2 == 0) ? 3 : 40;
      v = ($urandom_range(0, 9) < 7);
      t = 2'($urandom_range(0, 3));
      d = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(0, 31));
      r = ($urandom_range(0, ready_div - 1) == 0);
      f = ($urandom_range(0, 31) == 0);
      drive(v, t, d, r, f);
      model_cycle(v, t, d, r, f);
      tick();
      check_out($sformatf("rand%0d", c), m_we, m_sel, m_addr, m_busy, m_to);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
